// File: rtl/adder3_pkg.sv
// Shared definitions for the bit-serial (3-bit slice) adder controller:
// FSM state encoding, slice width and slice-index width helper.
package adder3_pkg;

  localparam int SLICE_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter able to address slices 0..nslice-1 (at least 1 bit).
  function automatic int idx_w(input int nslice);
    return (nslice <= 1) ? 1 : $clog2(nslice);
  endfunction

endpackage

// File: rtl/adder3_slice.sv
// Combinational 3-bit adder slice with carry in/out. With ADDER3_SEQ_OVF_EN
// defined it also exports the carry into its top bit for overflow detection.
module adder3_slice
  import adder3_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               ci,
  output logic [SLICE_W-1:0] s,
  output logic               co
`ifdef ADDER3_SEQ_OVF_EN
  ,
  output logic               c_top
`endif
);

  logic [2:0] lo;
  logic [1:0] hi;

  // Split at the top bit so its carry-in is visible for signed overflow.
  assign lo = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, ci};
  assign hi = {1'b0, a[2]} + {1'b0, b[2]} + {1'b0, lo[2]};
  assign s  = {hi[0], lo[1:0]};
  assign co = hi[1];

`ifdef ADDER3_SEQ_OVF_EN
  assign c_top = lo[2];
`endif

endmodule

// File: rtl/adder3_seq_ctrl.sv
// Sequential W-bit adder reusing one 3-bit slice per cycle, LSB slice first,
// with valid/ready handshakes. Optional overflow flag: ADDER3_SEQ_OVF_EN.
module adder3_seq_ctrl
  import adder3_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SLICE_W*NSLICE-1:0] x,
  input  logic [SLICE_W*NSLICE-1:0] y,
  input  logic                      cin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SLICE_W*NSLICE-1:0] sum,
  output logic                      cout,
  output logic                      busy
`ifdef ADDER3_SEQ_OVF_EN
  ,
  output logic                      ovf
`endif
);

  localparam int W  = SLICE_W * NSLICE;
  localparam int IW = idx_w(NSLICE);
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t               state;
  logic [IW-1:0]        idx;
  logic                 carry;
  logic [W-1:0]         xr;
  logic [W-1:0]         yr;
  logic [SLICE_W-1:0]   sa;
  logic [SLICE_W-1:0]   sb;
  logic [SLICE_W-1:0]   ss;
  logic                 sco;
`ifdef ADDER3_SEQ_OVF_EN
  logic                 sct;
`endif

  assign sa = xr[SLICE_W*idx +: SLICE_W];
  assign sb = yr[SLICE_W*idx +: SLICE_W];

  adder3_slice u_slice (
    .a     (sa),
    .b     (sb),
    .ci    (carry),
    .s     (ss),
    .co    (sco)
`ifdef ADDER3_SEQ_OVF_EN
    ,
    .c_top (sct)
`endif
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // NOTE: xr/yr are left out of reset; they are always loaded before use,
  // so resetting them would only add reset fan-out to the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef ADDER3_SEQ_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            xr    <= x;
            yr    <= y;
            carry <= cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sum[SLICE_W*idx +: SLICE_W] <= ss;
          carry <= sco;
          idx   <= idx + 1'b1;
          if (idx == LAST) begin
            idx   <= '0;
            cout  <= sco;
`ifdef ADDER3_SEQ_OVF_EN
            ovf   <= sct ^ sco;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder3_seq_ctrl.sv
// Self-checking bench for adder3_seq_ctrl (NSLICE = 4): arithmetic reference
// model with per-cycle comparison, plus directed literal checks.
`timescale 1ns/1ps
module tb_adder3_seq_ctrl;

  localparam int NSLICE = 4;
  localparam int W      = 3 * NSLICE;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef ADDER3_SEQ_OVF_EN
  logic         ovf;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adder3_seq_ctrl #(.NSLICE(NSLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef ADDER3_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request takes NSLICE cycles, then the result
  // is offered until taken. Result is plain modular arithmetic.
  int           m_cnt   = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  logic [W-1:0] p_sum;
  logic         p_cout;
  logic         p_ovf;
  bit           cmp_en  = 1'b0;

  always @(posedge clk) begin
    logic [W:0] full;
    if (!rst_n) begin
      m_cnt = 0; m_valid = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_cnt == 0 && !m_valid) begin
      if (in_valid) begin
        full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
        p_sum  = full[W-1:0];
        p_cout = full[W];
        p_ovf  = (x[W-1] == y[W-1]) && (p_sum[W-1] != x[W-1]);
        m_cnt  = NSLICE;
      end
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("in_ready",  in_ready,  (m_cnt == 0 && !m_valid));
      check("out_valid", out_valid, m_valid);
      check("busy",      busy,      (m_cnt != 0 || m_valid));
      if (m_cnt == 0) begin
        check("sum",  sum,  m_sum);
        check("cout", cout, m_cout);
`ifdef ADDER3_SEQ_OVF_EN
        check("ovf",  ovf,  m_ovf);
`endif
      end
    end
  end

  // Issue one request and wait (bounded) for the result; returns latency.
  task automatic send_op(input logic [W-1:0] xv, input logic [W-1:0] yv,
                         input logic cv, output int lat);
    int w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    x = xv; y = yv; cin = cv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_op(input string name, input logic [W-1:0] xv, input logic [W-1:0] yv,
                       input logic cv, input logic [W-1:0] es, input logic ec,
                       input logic eo);
    int lat;
    send_op(xv, yv, cv, lat);
    check({name, "_latency"}, lat, NSLICE);
    check({name, "_sum"}, sum, es);
    check({name, "_cout"}, cout, ec);
`ifdef ADDER3_SEQ_OVF_EN
    check({name, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) check({name, "_ovf_arg"}, 0, 1);
`endif
    release_result();
    check({name, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy,      0);
    check("rst_sum",       sum,       0);
    check("rst_cout",      cout,      0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    do_op("wrap",    12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0);
    do_op("alt_c1",  12'h555, 12'hAAA, 1'b1, 12'h000, 1'b1, 1'b0);
    do_op("alt_c0",  12'h555, 12'hAAA, 1'b0, 12'hFFF, 1'b0, 1'b0);
    do_op("ovf_pos", 12'h7FF, 12'h001, 1'b0, 12'h800, 1'b0, 1'b1);
    do_op("ovf_neg", 12'h800, 12'hFFF, 1'b0, 12'h7FF, 1'b1, 1'b1);

    // Back-pressure: result held, new request dropped.
    send_op(12'h123, 12'h456, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        x = 12'h0F0; y = 12'h00F; cin = 1'b1; in_valid = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
    end
    check("hold_out_valid", out_valid, 1);
    check("hold_in_ready",  in_ready,  0);
    check("hold_sum",       sum,       12'h579);
    check("hold_cout",      cout,      0);
    release_result();
    check("hold_sum_retained", sum, 12'h579);

    // Reset during the second ADD cycle aborts the operation.
    x = 12'h321; y = 12'h111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum",       sum,       0);
    check("abort_in_ready",  in_ready,  1);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("after_abort", 12'h321, 12'h111, 1'b1, 12'h433, 1'b0, 1'b0);

    // Low two slices swept exhaustively; upper bits set so carries ripple out.
    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        for (int c = 0; c < 2; c++) begin
          send_op({6'h3F, 6'(i)}, {6'h00, 6'(j)}, c[0], lat);
          release_result();
        end
      end
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
